// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one AXI4-Lite UART-lite TX path
// among NUM_REQ byte producers.
//
// Ports:
//   clk, rst (async, active-low)
//   req_data/req_valid/req_ready : per-requester byte handshake
//   grant_id, busy, err          : status (err is sticky)
//   aw*/w*/b*                    : AXI4-Lite write channels (master side)
//   ar*/r*                       : AXI4-Lite read channels (master side)
module uart_tx_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter logic [3:0] TX_FIFO_ADDR = 4'h4,
  parameter logic [3:0] STAT_ADDR    = 4'h8,
  parameter logic [3:0] CTRL_ADDR    = 4'hC,
  parameter logic [7:0] INIT_CTRL    = 8'h03
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err,
  output logic [3:0]           awaddr,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [7:0]           wdata,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic [3:0]           araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [7:0]           rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready
);

  localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_INIT_W  = 3'd0;
  localparam logic [2:0] S_INIT_B  = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_STAT_AR = 3'd3;
  localparam logic [2:0] S_STAT_R  = 3'd4;
  localparam logic [2:0] S_TX_W    = 3'd5;
  localparam logic [2:0] S_TX_B    = 3'd6;

  logic [2:0]    state;
  logic          issued;
  logic          aw_done;
  logic          w_done;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [7:0]    tx_byte;

  logic st_w;
  logic st_b;
  logic st_idle;
  logic st_ar;
  logic st_r;

  assign st_w    = (state == S_INIT_W) || (state == S_TX_W);
  assign st_b    = (state == S_INIT_B) || (state == S_TX_B);
  assign st_idle = (state == S_IDLE);
  assign st_ar   = (state == S_STAT_AR);
  assign st_r    = (state == S_STAT_R);

  assign busy = !st_idle;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // A requester whose completion pulse is high this cycle finishes its
  // handshake on this edge, so it must not be re-granted on the same edge.
  logic [NUM_REQ-1:0] elig;

  assign elig = req_valid & ~req_ready;

  logic [IW-1:0] pick;
  logic          found;
  logic [IW:0]   sum;

  always_comb begin
    pick  = ptr;
    found = 1'b0;
    sum   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ))
        sum = sum - (IW+1)'(NUM_REQ);
      if (!found && elig[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  logic [IW+2:0] bidx;
  logic [7:0]    pick_byte;

  assign bidx      = {pick, 3'b000};
  assign pick_byte = req_data[bidx +: 8];

  wire unused_ok = ^{rdata[7:4], rdata[2:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT_W;
      issued    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ptr       <= IW'(NUM_REQ-1);
      gnt       <= '0;
      tx_byte   <= '0;
      req_ready <= '0;
      grant_id  <= '0;
      err       <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
    end else begin
      req_ready <= '0;
      unique case (1'b1)
        st_w: begin
          if (!issued) begin
            issued  <= 1'b1;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (state == S_INIT_W) begin
              awaddr <= CTRL_ADDR;
              wdata  <= INIT_CTRL;
            end else begin
              awaddr <= TX_FIFO_ADDR;
              wdata  <= tx_byte;
            end
          end else begin
            if (aw_hs) begin
              awvalid <= 1'b0;
              aw_done <= 1'b1;
            end
            if (w_hs) begin
              wvalid <= 1'b0;
              w_done <= 1'b1;
            end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
              issued <= 1'b0;
              bready <= 1'b1;
              state  <= (state == S_INIT_W) ? S_INIT_B : S_TX_B;
            end
          end
        end
        st_b: begin
          if (bvalid && bready) begin
            bready <= 1'b0;
            if (bresp != 2'b00)
              err <= 1'b1;
            if (state == S_TX_B)
              req_ready <= NUM_REQ'(1) << gnt;
            state <= S_IDLE;
          end
        end
        st_idle: begin
          if (found) begin
            gnt      <= pick;
            ptr      <= pick;
            grant_id <= 3'(pick);
            tx_byte  <= pick_byte;
            state    <= S_STAT_AR;
          end
        end
        st_ar: begin
          if (!issued) begin
            issued  <= 1'b1;
            arvalid <= 1'b1;
            araddr  <= STAT_ADDR;
          end else if (arready) begin
            issued  <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_STAT_R;
          end
        end
        st_r: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (rresp != 2'b00) begin
              err   <= 1'b1;
              state <= S_STAT_AR;
            end else if (rdata[3]) begin
              state <= S_STAT_AR;
            end else begin
              state <= S_TX_W;
            end
          end
        end
        default: begin
          state  <= S_INIT_W;
          issued <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with an
// AXI-Lite slave model and a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [2:0]  grant_id;
  logic        busy;
  logic        err;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [7:0]  wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .grant_id(grant_id), .busy(busy), .err(err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // configuration written by the directed sequence
  int         w_dly;
  logic [1:0] bresp_cfg;
  logic [7:0] stat_arr [4];
  int         stat_len;
  int         target [N];

  // slave / requester environment state
  bit         aw_got, w_got, ar_got, b_fire, r_fire;
  int         w_cnt;
  int         stat_idx;
  int         served [N];
  int         rdy_cyc [N];
  int         rd_cnt;
  logic [3:0] rd_last;
  int         wonly;
  logic [3:0] aw_q [$];
  logic [7:0] w_q [$];
  logic [2:0] gid_q [$];

  initial begin
    rd_cnt = 0;
    wonly  = 0;
    for (int i = 0; i < N; i++) rdy_cyc[i] = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      awready = 0; wready = 0; arready = 0;
      rvalid = 0; bvalid = 0; bresp = 0; rresp = 0; rdata = 0;
      aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
      w_cnt = 0; stat_idx = 0; req_valid = '0;
      for (int i = 0; i < N; i++) served[i] = 0;
    end else begin
      if (b_fire) begin bvalid = 0; bresp = 0; b_fire = 0; end
      if (r_fire) begin
        rvalid = 0; rdata = 0; rresp = 0; r_fire = 0;
        stat_idx++;
      end
      if (aw_got && w_got && !bvalid) begin
        bvalid = 1; bresp = bresp_cfg; aw_got = 0; w_got = 0;
      end
      if (ar_got && !rvalid) begin
        rvalid = 1; rresp = 0; ar_got = 0;
        rdata = (stat_idx < stat_len) ? stat_arr[stat_idx] : 8'h00;
      end
      w_cnt   = wvalid ? w_cnt + 1 : 0;
      awready = awvalid;
      wready  = wvalid && (w_cnt > w_dly);
      arready = arvalid;
      if (wvalid && !awvalid) wonly++;
      if (awvalid && awready) begin
        aw_got = 1;
        aw_q.push_back(awaddr);
        gid_q.push_back(grant_id);
      end
      if (wvalid && wready) begin
        w_got = 1;
        w_q.push_back(wdata);
      end
      if (arvalid && arready) begin
        ar_got = 1; rd_cnt++; rd_last = araddr;
      end
      b_fire = bvalid && bready;
      r_fire = rvalid && rready;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) rdy_cyc[i]++;
        if (req_valid[i] && req_ready[i]) served[i]++;
        req_valid[i] = (served[i] < target[i]);
      end
    end
  end

  // reference model: transaction level, checked every cycle
  int         m_pass = 0, m_tot = 0;
  bit         m_init, m_ok, m_tx, m_awv, m_wv, m_err;
  int         m_ptr, m_g;
  logic [3:0] m_aw;
  logic [7:0] m_wd;
  logic [3:0] nxt_rdy;

  task automatic mchk(string nm, logic [31:0] act, logic [31:0] exp);
    m_tot++;
    if (act === exp) m_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int pick(logic [3:0] v, int p);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      m_init = 1; m_ok = 0; m_tx = 0; m_awv = 0; m_wv = 0;
      m_err = 0; m_ptr = N - 1; m_g = 0; nxt_rdy = '0;
      mchk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, |req_ready}, 0);
    end else begin
      mchk("req_ready", req_ready, nxt_rdy);
      nxt_rdy = '0;
      mchk("err", err, m_err);
      mchk("ar_r_overlap", arvalid && rvalid, 0);
      if (arvalid && arready) mchk("stat_addr", araddr, 4'h8);
      if (awvalid && awready) begin m_awv = 1; m_aw = awaddr; end
      if (wvalid && wready) begin m_wv = 1; m_wd = wdata; end
      if (m_awv && m_wv) begin
        m_awv = 0; m_wv = 0;
        if (m_init) begin
          mchk("init_wr", {m_aw, m_wd}, {4'hC, 8'h03});
          m_init = 0; m_tx = 0;
        end else begin
          m_g = pick(req_valid, m_ptr);
          mchk("grant_exists", m_g >= 0, 1);
          mchk("stat_before_tx", m_ok, 1);
          if (m_g >= 0) begin
            mchk("tx_wr", {m_aw, m_wd}, {4'h4, req_data[m_g*8 +: 8]});
            mchk("grant_id", grant_id, m_g);
            m_ptr = m_g;
          end
          m_tx = 1; m_ok = 0;
        end
      end
      if (bvalid && bready) begin
        if (bresp != 2'b00) m_err = 1;
        if (m_tx) nxt_rdy = 4'(1 << m_g);
        m_tx = 0;
      end
      if (rvalid && rready) begin
        if (rresp != 2'b00) m_err = 1;
        else if (!rdata[3]) m_ok = 1;
      end
    end
  end

  // directed sequence
  int d_pass = 0, d_tot = 0;

  task automatic dchk(string nm, logic [31:0] act, logic [31:0] exp);
    d_tot++;
    if (act === exp) d_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [11:0] wr_at(int k);
    if (k < aw_q.size() && k < w_q.size()) return {aw_q[k], w_q[k]};
    return 12'hxxx;
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_idle(string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (!busy) ok = 1;
    end
    dchk({nm, "_idle"}, ok, 1);
  endtask

  task automatic wait_served(string nm, int r, int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (served[r] >= n) ok = 1;
    end
    dchk({nm, "_served"}, ok, 1);
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) target[i] = 0;
    rst = 0;
    repeat (3) tick();
    rst = 1;
    wait_idle("reset");
  endtask

  int          base, rbase, cbase, tot;
  logic [7:0]  exp_b [5];
  logic [2:0]  exp_g [5];

  initial begin
    rst = 1; req_data = '0; w_dly = 0; bresp_cfg = 0; stat_len = 0;
    for (int i = 0; i < 4; i++) stat_arr[i] = 8'h00;
    for (int i = 0; i < N; i++) target[i] = 0;
    #1 rst = 0;

    // reset state
    tick();
    dchk("rst_busy", busy, 1);
    dchk("rst_err", err, 0);
    dchk("rst_gid", grant_id, 0);
    dchk("rst_valid", {awvalid, wvalid, arvalid, bready, rready, req_ready}, 0);
    dchk("rst_addr", {awaddr, araddr, wdata}, 0);
    rst = 1;
    wait_idle("t1");
    dchk("t1_nwr", aw_q.size(), 1);
    dchk("t1_ctrl_wr", wr_at(0), {4'hC, 8'h03});
    dchk("t1_nrd", rd_cnt, 0);
    dchk("t1_no_rdy", rdy_cyc[0] + rdy_cyc[1] + rdy_cyc[2] + rdy_cyc[3], 0);

    // single requester
    base = aw_q.size(); rbase = rd_cnt; cbase = rdy_cyc[0];
    req_data[7:0] = 8'h41;
    target[0] = 1;
    wait_served("t2", 0, 1);
    repeat (3) tick();
    dchk("t2_nrd", rd_cnt - rbase, 1);
    dchk("t2_rd_addr", rd_last, 4'h8);
    dchk("t2_tx_wr", wr_at(base), {4'h4, 8'h41});
    dchk("t2_pulse", rdy_cyc[0] - cbase, 1);
    dchk("t2_busy", busy, 0);

    // all four requesters, round robin
    do_reset();
    base = aw_q.size();
    req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    target[0] = 2; target[1] = 1; target[2] = 1; target[3] = 1;
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
        tick();
        tot = served[0] + served[1] + served[2] + served[3];
        if (tot >= 5) ok = 1;
      end
      dchk("t3_served", ok, 1);
    end
    exp_b = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
    exp_g = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    for (int k = 0; k < 5; k++) begin
      dchk($sformatf("t3_wr%0d", k), wr_at(base + k), {4'h4, exp_b[k]});
      dchk($sformatf("t3_gid%0d", k),
           (base + k < gid_q.size()) ? gid_q[base + k] : 3'bxxx, exp_g[k]);
    end

    // status polling while TX FIFO is full
    stat_arr[0] = 8'h08; stat_arr[1] = 8'h08;
    stat_arr[2] = 8'h08; stat_arr[3] = 8'h00;
    stat_len = 4;
    do_reset();
    base = aw_q.size(); rbase = rd_cnt;
    req_data[15:8] = 8'h5A;
    target[1] = 1;
    wait_served("t4", 1, 1);
    dchk("t4_nrd", rd_cnt - rbase, 4);
    dchk("t4_nwr", aw_q.size() - base, 1);
    dchk("t4_tx_wr", wr_at(base), {4'h4, 8'h5A});
    stat_len = 0;

    // slow wready and error write response
    do_reset();
    w_dly = 3; bresp_cfg = 2'b10;
    cbase = wonly; base = aw_q.size();
    req_data[23:16] = 8'h77;
    target[2] = 1;
    wait_served("t5", 2, 1);
    tick();
    dchk("t5_wonly", wonly - cbase, 3);
    dchk("t5_err", err, 1);
    dchk("t5_tx_wr", wr_at(base), {4'h4, 8'h77});
    w_dly = 0; bresp_cfg = 2'b00;
    req_data[31:24] = 8'h33;
    target[3] = 1;
    wait_served("t5b", 3, 1);
    tick();
    dchk("t5_err_sticky", err, 1);

    // reset during TX_B
    do_reset();
    req_data[7:0] = 8'h11;
    target[0] = 1;
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        tick();
        if (bready && awaddr == 4'h4) ok = 1;
      end
      dchk("t6_txb", ok, 1);
    end
    rst = 0;
    #1;
    dchk("t6_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    dchk("t6_busy", busy, 1);
    base = aw_q.size();
    repeat (3) tick();
    rst = 1;
    wait_served("t6", 0, 1);
    dchk("t6_ctrl_wr", wr_at(base), {4'hC, 8'h03});
    dchk("t6_tx_wr", wr_at(base + 1), {4'h4, 8'h11});

    repeat (3) tick();
    $display("%0d/%0d checks passed", d_pass + m_pass, d_tot + m_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one AXI4-Lite UART-lite core (TX path) between NUM_REQ byte producers.
- After reset it issues one CTRL register write that clears both FIFOs.
- Each transfer: round-robin grant, then poll STAT until the TX FIFO is not full, then write the byte to TX_FIFO.
- Sits between the producer blocks (ROM readers, status reporters) and the UART-lite core, and replaces the single-source UART controller.

Parameters:
- NUM_REQ, 4, number of byte requesters (2..8).
- TX_FIFO_ADDR, 4'h4, AXI address of the TX FIFO register.
- STAT_ADDR, 4'h8, AXI address of the status register.
- CTRL_ADDR, 4'hC, AXI address of the control register.
- INIT_CTRL, 8'h03, value written to CTRL after reset (reset TX and RX FIFOs).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_data  in  NUM_REQ*8  byte of requester i on bits [8i+7:8i].
- req_valid  in  NUM_REQ  requester i has a byte; held high with data stable until its req_ready.
- req_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- grant_id  out  3  index of the current or last grantee.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky; set on any nonzero bresp or rresp, cleared only by reset.
- awaddr  out  4  AXI write address.
- awvalid  out  1  AXI write-address valid.
- awready  in  1  AXI write-address ready.
- wdata  out  8  AXI write data; the top level zero-extends it to 32 bits.
- wvalid  out  1  AXI write-data valid.
- wready  in  1  AXI write-data ready.
- bresp  in  2  AXI write response.
- bvalid  in  1  AXI write-response valid.
- bready  out  1  AXI write-response ready.
- araddr  out  4  AXI read address.
- arvalid  out  1  AXI read-address valid.
- arready  in  1  AXI read-address ready.
- rdata  in  8  low byte of the AXI read data.
- rresp  in  2  AXI read response.
- rvalid  in  1  AXI read-data valid.
- rready  out  1  AXI read-data ready.

Behaviour:
- Reset values:
  - All valid/ready outputs 0; awaddr, araddr, wdata, grant_id = 0; err = 0.
  - busy = 1, because the FSM enters INIT.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- FSM states: INIT_W, INIT_B, IDLE, STAT_AR, STAT_R, TX_W, TX_B.
- Write sub-protocol (shared by INIT_W and TX_W):
  - Assert awvalid and wvalid in the same cycle.
  - Drop each one independently in the cycle after its own ready is sampled high.
  - Leave the state once both handshakes have completed, in any order or simultaneously.
  - Address and data stay stable until their handshake completes.
  - In the *_B state, hold bready = 1 until bvalid; nonzero bresp sets err.
- INIT_W / INIT_B:
  - Write INIT_CTRL to CTRL_ADDR, then go to IDLE.
  - Requesters are ignored until IDLE.
- IDLE / arbitration:
  - If any req_valid is high, grant the first set bit searching upward from pointer+1 with wrap.
  - Latch that byte and the grantee index, update the pointer and grant_id, go to STAT_AR.
  - Arbitration decides in one cycle; the latched byte is used even if the requester later changes data (a protocol violation).
- STAT_AR: arvalid = 1 with araddr = STAT_ADDR until arready, then go to STAT_R.
- STAT_R: rready = 1 until rvalid, then:
  - rresp != 0: set err, go to STAT_AR.
  - rdata[3] = 1 (TX FIFO full): go to STAT_AR. Polling is unbounded and has no timeout.
  - Otherwise: go to TX_W with awaddr = TX_FIFO_ADDR and wdata = latched byte.
- TX_B: on bvalid & bready, pulse req_ready[grantee] for exactly one cycle and go to IDLE.
  - The pulse occurs even on a bresp error; in that case the byte is dropped and err is set.
- Grant spacing: a requester is not re-granted before every other valid requester has been served once.
- Simultaneous events:
  - A req_valid that deasserts after grant does not abort the transfer; it completes.
  - The rvalid cycle and the next arvalid never overlap: there is at least one cycle between them.
- Reset mid-operation: all outstanding AXI valids drop asynchronously and the FSM restarts at INIT_W. The UART core shares the reset, so there are no orphan transactions.
- Throughput: at most one byte per transfer cycle; minimum transfer is 7 cycles with zero-wait slave readies.

Test Plan:
- Reset release, slave with zero-wait readies -> first AW/W carries addr 0xC, data 0x03; busy falls after bvalid; no req_ready pulse.
- req_valid=4'b0001, byte 0x41 -> read of addr 0x8, then write of addr 0x4 with data 0x41; req_ready[0] pulses one cycle.
- All four requesters held valid with bytes 0x41..0x44 -> TX_FIFO writes in order 0x41, 0x42, 0x43, 0x44, 0x41, ...; grant_id cycles 0, 1, 2, 3, 0.
- Status returns rdata=0x08 three times, then 0x00 -> exactly four STAT reads, one TX write; byte is unchanged.
- wready delayed 3 cycles after awready, then bresp=2'b10 -> awvalid drops first and wvalid holds 3 cycles; err goes to 1 and stays; req_ready still pulses.
- rst pulled low during TX_B, then released -> all AXI valids are 0 during reset; next transaction is the CTRL write of 0x03.
